// File: rtl/nibble_blink_tx_pkg.sv
// nibble_blink_tx_pkg: state encodings and 100 MHz default timing for the nibble blink path
package nibble_blink_tx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;
  localparam int N_DEF       = 4;
  localparam int T_SHORT_DEF = 20_000_000;
  localparam int T_LONG_DEF  = 60_000_000;
  localparam int T_GAP_DEF   = 40_000_000;
endpackage

// File: rtl/nibble_blink_tx_blink_timer.sv
// blink_timer: loadable down-counter; expire is high during the last cycle of a loaded period
module blink_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = cnt == W'(1);
endmodule

// File: rtl/nibble_blink_tx.sv
// nibble_blink_tx: plays an N-bit word MSB first on one LED as short/long pulses with fixed gaps.
// Define NIBBLE_BLINK_TX_SYNC_EN to treat start as a raw push-button level (sync + edge detect).
module nibble_blink_tx
  import nibble_blink_tx_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int T_SHORT = T_SHORT_DEF,
  parameter int T_LONG  = T_LONG_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         led,
  output logic         busy,
  output logic         done
);
  localparam int TW = $clog2(T_LONG + 1);
  localparam int CW = $clog2(N);
  state_t state, state_n;
  logic [N-1:0] sr, sr_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] load_val;
  logic req, expire, go, gap_end, more, load, led_n, busy_n, done_n;
`ifdef NIBBLE_BLINK_TX_SYNC_EN
  // two sync flops, one edge-history flop, then a registered accept pulse
  logic [2:0] sync;
  logic req_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync  <= '0;
      req_r <= 1'b0;
    end else begin
      sync  <= {sync[1:0], start};
      req_r <= sync[1] & ~sync[2];
    end
  assign req = req_r;
`else
  assign req = start;
`endif
  blink_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .expire(expire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      led   <= led_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  always_comb begin
    go       = state == IDLE && req;
    gap_end  = state == GAP && expire;
    more     = cnt != '0;
    sr_n     = go ? data : (gap_end && more) ? sr << 1 : sr;
    load     = go || (state == ON && expire) || (gap_end && more);
    load_val = state == ON ? TW'(T_GAP) : sr_n[N-1] ? TW'(T_LONG) : TW'(T_SHORT);
    state_n  = go ? ON : (state == ON && expire) ? GAP : gap_end ? (more ? ON : IDLE) : state;
  end
  always_comb begin
    led_n  = state_n == ON;
    busy_n = state_n != IDLE;
    done_n = gap_end && !more;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= sr_n;
      cnt <= go ? CW'(N - 1) : (gap_end && more) ? cnt - 1'b1 : cnt;
    end
endmodule

// File: tb/tb_nibble_blink_tx.sv
// tb_nibble_blink_tx: scoreboard bench; expected {led,busy,done} per cycle queued at stimulus time
module tb_nibble_blink_tx;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] data = '0;
  logic led, busy, done;
  logic [2:0] exp_q[$];
  int checks = 0, errors = 0;

  nibble_blink_tx #(.N(4), .T_SHORT(2), .T_LONG(5), .T_GAP(3)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) begin
      for (int k = 0; k < (d[i] ? 5 : 2); k++) exp_q.push_back(3'b110);
      for (int k = 0; k < 3; k++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(3'b000);
  endtask

  task automatic check_one(input int c);
    logic [2:0] e;
    e = exp_q.pop_front();
    checks++;
    assert ({led, busy, done} === e)
    else begin
      errors++;
      $error("FAIL cycle%0d {led,busy,done} observed=%b expected=%b", c, {led, busy, done}, e);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({led, busy, done} === 3'b000)
    else begin
      errors++;
      $error("FAIL %s {led,busy,done} observed=%b expected=000", tag, {led, busy, done});
    end
  endtask

  // first edge of a playback: start accepted, cycle 1 checked
  task automatic pulse(input logic [3:0] d);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_one(1);
  endtask

  // step until the queue empties or lim cycles; start driven during cycles a and b with word d
  task automatic drain(input int a, input int b, input logic [3:0] d, input int lim);
    int c = 1;
    while (exp_q.size() > 0 && c < lim) begin
      if (c == a || c == b) begin
        start = 1'b1;
        data  = d;
      end
      @(posedge clk);
      #1 start = 1'b0;
      c++;
      check_one(c);
    end
  endtask

  initial begin
    #2 check_zero("reset_state");
    @(posedge clk);
    #1 check_zero("reset_held");
    reset = 1'b0;
    @(posedge clk);
    #1 check_zero("idle_after_reset");

    push_word(4'b1010); push_idle(2);
    pulse(4'b1010); drain(0, 0, 4'b0000, 1000);

    push_word(4'b0000); push_idle(1);
    pulse(4'b0000); drain(0, 0, 4'b0000, 1000);

    push_word(4'b1111); push_idle(1);
    pulse(4'b1111); drain(0, 0, 4'b0000, 1000);

    push_word(4'b1010); push_idle(2);
    pulse(4'b1010); drain(4, 15, 4'b0101, 1000);

    push_word(4'b1010);
    pulse(4'b1010); drain(0, 0, 4'b0000, 10);
    #2 reset = 1'b1;
    #1 check_zero("async_reset_mid_bit");
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 check_zero("idle_after_abort");
    push_word(4'b1010); push_idle(1);
    pulse(4'b1010); drain(0, 0, 4'b0000, 1000);

    push_word(4'b1010); push_word(4'b0001); push_idle(2);
    pulse(4'b1010); drain(27, 0, 4'b0001, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_blink_tx.md
Name: nibble_blink_tx

Overview:
Transmit-side counterpart of the push-button nibble capture path. It accepts a parallel N-bit word and a start request, then plays the word out serially on a single LED, MSB first. Each bit is a timed ON pulse (short = 0, long = 1) followed by a fixed OFF gap. It sits between the captured bus and an Arty A7 LED pin and gives the user visual read-back of what was entered.

Parameters:
N, 4, word width in bits; must be >= 2.
T_SHORT, 20_000_000, ON duration in clk cycles for a 0 bit (0.2 s at 100 MHz); >= 1.
T_LONG, 60_000_000, ON duration in clk cycles for a 1 bit; must be > T_SHORT.
T_GAP, 40_000_000, OFF duration in clk cycles after every bit; >= 1.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high; clock clk
start  input  1  playback request; one-cycle pulse (see Optional Feature)
data  input  N  word to transmit; sampled only when start is accepted
led  output  1  serial blink output, registered
busy  output  1  high while a word is being played
done  output  1  one-cycle pulse when playback completes

Behaviour:
- Reset (async): state IDLE, led=0, busy=0, done=0, shift register=0, bit counter=0, timer=0. Reset mid-playback aborts immediately; there is no done pulse.
- States: IDLE, ON, GAP.
- IDLE: start=1 is accepted on edge k. Latch data into the shift register and load bit counter=N-1. Load timer from the MSB: T_LONG if MSB=1, T_SHORT if MSB=0. Go to ON. led=1 and busy=1 from cycle k+1.
- ON: led=1. Timer counts down once per cycle. When the period expires, load T_GAP and go to GAP. The ON phase lasts exactly T_SHORT or T_LONG cycles.
- GAP: led=0 for exactly T_GAP cycles. On expiry:
  - If bit counter != 0: shift the register left by 1, decrement the counter, load the timer from the new MSB, go to ON.
  - If bit counter == 0: go to IDLE, busy=0, done=1 for that one cycle.
- Total playback is the sum over bits of (T_bit + T_GAP) cycles. done rises on the cycle after the last gap cycle.
- start while busy=1 is ignored. There is no queueing, and data changes during playback have no effect.
- start on the same cycle done=1 is accepted, because the FSM is already IDLE. Back-to-back words are therefore separated only by the final gap.
- Timer width is $clog2(T_LONG+1). T_GAP and T_SHORT must fit in it.
- No combinational paths from inputs to outputs.

Optional Feature:
Macro: NIBBLE_BLINK_TX_SYNC_EN.
- Defined: start is treated as a raw asynchronous push-button level. It passes through a two-flop synchronizer plus rising-edge detect, and the internal accept pulse appears 3 cycles after the pin rises. Holding the button produces exactly one request.
- Undefined: start is a clean, clk-synchronous one-cycle pulse used directly, with zero added latency. A start held high for multiple cycles re-triggers on the first idle cycle after done.

Decomposition:
- Shared include/package: state encodings (IDLE=2'd0, ON=2'd1, GAP=2'd2) and the default timing constants for 100 MHz, so they are reused by the capture block's top level.
- One natural sub-module, blink_timer: a loadable down-counter with a one-cycle expire output.
  - Ports: clk, reset, load, load_val, expire.
  - The FSM and shift register stay in nibble_blink_tx.

Test Plan:
All scenarios use T_SHORT=2, T_LONG=5, T_GAP=3, N=4, sync macro undefined. Start is pulsed on edge 0.
- data=4'b1010 -> led high cycles 1-5, low 6-8, high 9-10, low 11-13, high 14-18, low 19-21, high 22-23, low 24-26; done=1 only on cycle 27; busy high cycles 1-26.
- data=4'b0000 -> four 2-on/3-off pulses, done on cycle 21. data=4'b1111 -> four 5-on/3-off pulses, done on cycle 33.
- data=4'b1010 followed by start pulses on cycles 4 and 15 with data=4'b0101 -> both ignored, and the output is identical to the first scenario.
- reset asserted asynchronously at cycle 10 (mid-bit) -> led, busy and done are 0 immediately; a subsequent start replays from the MSB with correct timing.
- start asserted on the cycle done=1 with data=4'b0001 -> led high on the following cycle and the new word plays with no extra idle cycles.
- Sync macro defined: start held high for 50 cycles -> exactly one playback, with led first high 4 cycles after start rises.
